// File: rtl/teststructure_pkg.sv
// -----------------------------------------------------------------------------
// teststructure_pkg
// Shared definitions for the test-structure readout blocks.
//   - Default widths and synchronizer depth for the frequency counter.
//   - FSM state type used by teststructure_freq_counter.
// -----------------------------------------------------------------------------
package teststructure_pkg;

    localparam int CNT_W_DEF       = 24;  // edge-count width
    localparam int WIN_W_DEF       = 24;  // gate-window length width
    localparam int SYNC_STAGES_DEF = 2;   // synchronizer depth (2..4)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : teststructure_pkg

// File: rtl/teststructure_sync.sv
// -----------------------------------------------------------------------------
// teststructure_sync
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears every stage
//   d      - asynchronous input
//   q      - synchronized output (STAGES clock cycles of latency)
// -----------------------------------------------------------------------------
module teststructure_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: flop state uses non-blocking assignments so every stage samples
    // the value its predecessor held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : teststructure_sync

// File: rtl/teststructure_freq_counter.sv
// -----------------------------------------------------------------------------
// teststructure_freq_counter
// Counts rising edges of an asynchronous test-structure output (ring
// oscillator / gpio probe) over a programmable gate window of wb_clk_i cycles.
// Ports:
//   wb_clk_i   - sole clock, rising edge
//   wb_rst_ni  - asynchronous active-low reset
//   meas_i     - asynchronous signal to be measured
//   start_i    - single-cycle request to begin a measurement (IDLE only)
//   abort_i    - cancels any measurement in progress, wins over start_i
//   window_i   - gate length in cycles, sampled when start is accepted
//   busy_o     - high while the gate window is open
//   done_o     - one-cycle pulse when count_o / overflow_o are updated
//   count_o    - edges counted in the last completed window (saturating)
//   overflow_o - an edge arrived while the count was saturated
// -----------------------------------------------------------------------------
module teststructure_freq_counter
    import teststructure_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             meas_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] window_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t           state, state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] work_cnt, work_cnt_nxt;
    logic             work_ovf, work_ovf_nxt;
    logic             meas_sync, meas_q, edge_p;

    // ---------------------------------------------------------------- edges
    teststructure_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (meas_i),
        .q     (meas_sync)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            meas_q <= 1'b0;
        end else begin
            meas_q <= meas_sync;
        end
    end

    assign edge_p = meas_sync & ~meas_q;

    // ------------------------------------------------------- state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // --------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start_i) state_nxt = (window_i != '0) ? ST_COUNT : ST_DONE;
                ST_COUNT: if (win_cnt == WIN_ONE) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- outputs
    always_comb begin
        busy_o = (state == ST_COUNT);
        done_o = (state == ST_DONE);
    end

    // ------------------------------------------------------ working count
    // Saturating count: an edge seen at full scale flags overflow instead
    // of wrapping. The edge in the last window cycle is included.
    always_comb begin
        work_cnt_nxt = work_cnt;
        work_ovf_nxt = work_ovf;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    work_cnt_nxt = '0;
                    work_ovf_nxt = 1'b0;
                end
            end
            ST_COUNT: begin
                if (edge_p) begin
                    if (work_cnt == CNT_MAX) work_ovf_nxt = 1'b1;
                    else                     work_cnt_nxt = work_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            win_cnt    <= '0;
            work_cnt   <= '0;
            work_ovf   <= 1'b0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            work_cnt <= work_cnt_nxt;
            work_ovf <= work_ovf_nxt;
            if (state == ST_IDLE && start_i && !abort_i) begin
                win_cnt <= window_i;
            end else if (state == ST_COUNT) begin
                win_cnt <= win_cnt - WIN_ONE;
            end
            // Publish the result on entry to DONE so it is visible in the
            // same cycle as done_o; an abort never reaches DONE.
            if (state_nxt == ST_DONE) begin
                count_o    <= work_cnt_nxt;
                overflow_o <= work_ovf_nxt;
            end
        end
    end

endmodule : teststructure_freq_counter

// File: doc/teststructure_freq_counter.md
TESTSTRUCTURE_FREQ_COUNTER -- requirements
Module: teststructure_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of edge count.
REQ-002 SHALL have parameter WIN_W, default 24, width of gate window length.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal range 2..4).
REQ-004 SHALL have port wb_clk_i  input  1  sole clock; one clock, rising edge.
REQ-005 SHALL have port wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port meas_i  input  1  asynchronous test-structure output (ring oscillator / gpio probe) to be measured.
REQ-007 SHALL have port start_i  input  1  single-cycle request to begin a measurement.
REQ-008 SHALL have port abort_i  input  1  cancels any measurement in progress.
REQ-009 SHALL have port window_i  input  WIN_W  gate length in wb_clk_i cycles, sampled on accepted start.
REQ-010 SHALL have port busy_o  output  1  high while in COUNT.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse when count_o is updated.
REQ-012 SHALL have port count_o  output  CNT_W  rising edges of meas_i counted in the last completed window.
REQ-013 SHALL have port overflow_o  output  1  count saturated in the last completed window.

Function
REQ-014 SHALL pass meas_i through a SYNC_STAGES flop synchronizer, then a one-flop rising-edge detector producing edge_p.
REQ-015 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-016 IDLE: start_i=1 with window_i!=0 -> COUNT; load window counter with window_i, clear working count and overflow flag.
REQ-017 IDLE: start_i=1 with window_i==0 -> DONE directly; working count 0, overflow 0.
REQ-018 COUNT SHALL last exactly window_i cycles; each cycle with edge_p=1 increments the working count.
REQ-019 Working count SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets the overflow flag; no wrap-around.
REQ-020 On the last COUNT cycle (window counter ==1), FSM SHALL go to DONE; an edge_p in that last cycle SHALL be counted.
REQ-021 DONE SHALL last one cycle: done_o=1, count_o and overflow_o updated in that same cycle, then -> IDLE.
REQ-022 count_o and overflow_o SHALL hold their values until the next DONE; they change only in DONE.
REQ-023 start_i SHALL be ignored in COUNT and DONE; window_i changes after acceptance SHALL have no effect.
REQ-024 abort_i=1 in any state SHALL force IDLE next cycle with no done_o; count_o/overflow_o keep previous values; abort_i wins over simultaneous start_i.
REQ-025 busy_o SHALL equal (state==COUNT); maximum measurable rate is wb_clk_i/2.
REQ-026 Edge-to-count latency SHALL be SYNC_STAGES+1 cycles from meas_i transition; edges in flight at window end SHALL NOT be counted.

Reset
REQ-027 On wb_rst_ni=0: state IDLE; busy_o, done_o, overflow_o =0; count_o =0; synchronizer and edge flops =0; window counter and working count =0.
REQ-028 Reset asserted mid-COUNT SHALL discard the measurement without a done_o pulse.
REQ-029 A meas_i held high across reset release MAY produce one edge_p; it SHALL be counted only if in COUNT.

Structure
REQ-030 Shared package teststructure_pkg SHALL hold the FSM state enum type and the default CNT_W/WIN_W/SYNC_STAGES constants.
REQ-031 Synchronizer SHALL be sub-module teststructure_sync (parameterized depth, async active-low reset), reusable by other test-structure readout blocks.

Verification
REQ-032 meas_i = clk/8 square wave, window_i=800, start pulse -> done_o exactly 801 cycles after start accepted, count_o=100 (+/-1), overflow_o=0.
REQ-033 CNT_W=4 build, meas_i = clk/2, window_i=100 -> count_o=15, overflow_o=1.
REQ-034 window_i=0, start pulse -> done_o one cycle later, count_o=0, busy_o never high.
REQ-035 Window 1000 running, abort_i at cycle 500 -> busy_o low next cycle, no done_o, count_o retains prior result; second start_i during COUNT ignored (single done_o).
REQ-036 Reset asserted mid-COUNT, then released -> all outputs 0, new start with window_i=16, meas_i static low -> count_o=0.
